// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode field layout and fetch FSM states.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 8;
    localparam int unsigned CPU_INSN_W = 16;

    // Opcode field position inside an instruction word
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 13;
    localparam logic [2:0]  OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, RAM read sequencing, valid/ready hand-off to execute,
// branch redirect and permanent stop on HALT.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned INSN_W = CPU_INSN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              mem_grant,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INSN_W-1:0] mem_rdata,
    output logic [INSN_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= start_pc;
            ir_q    <= '0;
            ir_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

    // Next state; redirect wins everywhere except HALT and drops any read in flight
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        mem_rd  = 1'b0;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (mem_grant) begin
                    mem_rd  = ~rst;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (mem_rdata[OPC_HI:OPC_LO] == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    ir_d    = mem_rdata;
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (ir_ready) begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign mem_addr = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = (state_q == HOLD);
    assign halted   = (state_q == HALT);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the simple RISC CPU. It holds the program counter, reads 16-bit instructions from the shared synchronous RAM whenever the data path grants the port, and presents each instruction to the decode/execute stage over a valid/ready handshake. It also accepts branch redirects and stops permanently on a HALT opcode until reset. The block sits directly upstream of the controller/datapath and downstream of the memory arbiter.

## Interface
Parameters:
- ADDR_W, 8, PC and memory address width
- INSN_W, 16, instruction width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- start_pc  in  ADDR_W  PC loaded while rst is high
- mem_grant  in  1  fetch may use the memory port this cycle
- mem_rd  out  1  read strobe, asserted only when mem_grant=1
- mem_addr  out  ADDR_W  read address; equals pc
- mem_rdata  in  INSN_W  read data, valid the cycle after mem_rd
- ir  out  INSN_W  instruction presented to execute
- ir_pc  out  ADDR_W  address ir was fetched from
- ir_valid  out  1  ir is valid
- ir_ready  in  1  execute accepts ir
- redirect  in  1  branch taken; load redirect_pc
- redirect_pc  in  ADDR_W  branch target
- halted  out  1  HALT fetched; fetch stopped

## Operation
- States: FETCH, WAIT, HOLD, HALT.
- While rst=1:
  - pc<=start_pc, state<=FETCH.
  - ir<=0, ir_pc<=0, ir_valid=0, halted=0.
  - mem_rd=0. This applies from any state, including mid-fetch or HALT.
- FETCH:
  - If mem_grant=1: mem_rd=1, next state WAIT.
  - Otherwise mem_rd=0 and the stage stays in FETCH.
- WAIT:
  - If mem_rdata[15:13]==3'b111 (HALT): next state HALT, ir unchanged, pc unchanged.
  - Otherwise: ir<=mem_rdata, ir_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, so 8'hFF wraps to 8'h00), next state HOLD.
- HOLD:
  - ir_valid=1.
  - A transfer is ir_valid & ir_ready & ~redirect.
  - On transfer, next state FETCH. Otherwise hold ir and ir_pc stable.
- HALT:
  - halted=1, ir_valid=0, mem_rd=0.
  - redirect is ignored. Only rst exits.
- redirect (any state except HALT):
  - Highest priority after rst: pc<=redirect_pc, next state FETCH.
  - A read issued in WAIT is discarded. ir is not updated and no HALT check is made.
  - An instruction in HOLD is squashed: it is not transferred, even if ir_ready=1.
- mem_addr is combinationally equal to pc in all states.
- ir_valid and halted are decoded from state, with no combinational path from inputs.
- mem_rd = (state==FETCH) & mem_grant & ~rst & ~redirect.

## Timing
- Fetch latency: 3 cycles from the FETCH cycle with mem_grant=1 to ir_valid=1 (FETCH, WAIT, HOLD).
- First instruction: with mem_grant=1, ir_valid rises on the 3rd posedge after rst falls.
- Throughput: at most one instruction per 3 cycles. With ir_ready held high, ir_valid is high 1 cycle in 3.
- mem_grant low in FETCH stalls the stage for exactly that many cycles. mem_grant is ignored in WAIT and HOLD.
- Redirect: the new PC is read in the cycle after redirect (given grant), and its ir_valid appears 3 cycles after redirect.
- halted rises 2 cycles after the FETCH of the HALT word and never deasserts without rst.

## Structure
- Shared package cpu_pkg holds:
  - OP_HALT = 3'b111 and the opcode field position [15:13].
  - fetch_state_t enum {FETCH, WAIT, HOLD, HALT}.
  - ADDR_W/INSN_W defaults, shared with the datapath and RAM.
- Single module with no sub-module; the PC register, redirect mux and incrementer are inline. Target size is about 150 lines.

## Test plan
- Reset with start_pc=8'h29 and RAM[29]=16'hD04E (MOV R0,#78), mem_grant=1, ir_ready=1 → mem_addr=8'h29 at the first cycle after reset; ir=16'hD04E, ir_pc=8'h29, ir_valid=1 at cycle 3; next read from 8'h2A.
- ir_ready=0 for 5 cycles in HOLD → ir and ir_pc stay stable, mem_rd=0 throughout; ir_ready=1 → transfer, next fetch from pc+1.
- mem_grant=0 for 4 cycles in FETCH → mem_rd=0, no state change; first ir_valid is delayed by exactly 4 cycles.
- Program from 8'hFE: pc=8'hFE then 8'hFF, then the next fetch is at 8'h00 (wrap).
- redirect=1, redirect_pc=8'hB0 while in WAIT → returning data is dropped (ir unchanged), the next read is at 8'hB0; redirect in HOLD with ir_ready=1 → no transfer is counted.
- RAM[2B]=16'hE000 (HALT) → halted=1 two cycles after its read, ir_valid stays 0, redirect is ignored, mem_rd=0 for 20 cycles; rst with start_pc=8'h00 → halted=0 and fetch restarts at 8'h00.
